// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S frame-collecting loopback FIFO.
package i2s_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } asm_state_e;

    localparam int unsigned MAX_CHANNELS = 8;

    // Channel-select width; a single-channel build still needs one bit.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned frame_w(input int unsigned dw, input int unsigned ch);
        return dw * ch;
    endfunction

endpackage

// File: rtl/i2s_loop_fifo_if.sv
// Sample-in / frame-out bundle of the I2S loopback FIFO.
// drop_cnt is present only when I2S_LOOP_DROP_CNT_EN is defined.
interface i2s_loop_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned DEPTH      = 4
);
    import i2s_pkg::*;

    localparam int unsigned CH_W   = sel_w(CHANNELS);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0]          data;
    logic                           in_vld;
    logic [CH_W-1:0]                in_ch;
    logic [CHANNELS*DATA_WIDTH-1:0] frame;
    logic                           out_vld;
    logic                           out_rdy;
    logic [ADDR_W:0]                level;
    logic                           overflow;
    logic                           ovf_clr;
    logic                           sync_err;
`ifdef I2S_LOOP_DROP_CNT_EN
    logic [15:0]                    drop_cnt;

    modport master (output data, in_vld, in_ch, out_rdy, ovf_clr,
                    input  frame, out_vld, level, overflow, sync_err, drop_cnt);
    modport slave  (input  data, in_vld, in_ch, out_rdy, ovf_clr,
                    output frame, out_vld, level, overflow, sync_err, drop_cnt);
`else
    modport master (output data, in_vld, in_ch, out_rdy, ovf_clr,
                    input  frame, out_vld, level, overflow, sync_err);
    modport slave  (input  data, in_vld, in_ch, out_rdy, ovf_clr,
                    output frame, out_vld, level, overflow, sync_err);
`endif
endinterface

// File: rtl/i2s_frame_fifo.sv
// Synchronous frame FIFO with registered head output and fill level.
module i2s_frame_fifo #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              pop_rdy,
    output logic [WIDTH-1:0]  rdata,
    output logic              vld,
    output logic [ADDR_W:0]   level,
    output logic              full_c
);
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, level_q, level_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;
    logic              vld_q, vld_d;
    logic              pop_c, push_en_c;
    logic [ADDR_W-1:0] wr_ptr_c, rd_ptr_d;

    assign full_c    = (level_q == CNT_W'(DEPTH));
    assign pop_c     = vld_q & pop_rdy;
    assign push_en_c = push & (~full_c | pop_c);
    assign wr_ptr_c  = wr_cnt_q[ADDR_W-1:0];

    // Next head is prefetched; the only write that can land on it is the one
    // entering an otherwise empty FIFO, so forward wdata in that case.
    always_comb begin
        wr_cnt_d = wr_cnt_q + CNT_W'(push_en_c);
        rd_cnt_d = rd_cnt_q + CNT_W'(pop_c);
        level_d  = wr_cnt_d - rd_cnt_d;
        vld_d    = (level_d != '0);
        rd_ptr_d = rd_cnt_d[ADDR_W-1:0];
        rdata_d  = '0;
        if (vld_d) begin
            rdata_d = (push_en_c && (wr_ptr_c == rd_ptr_d)) ? wdata : mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push_en_c) begin
            mem[wr_ptr_c] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            level_q  <= '0;
            rdata_q  <= '0;
            vld_q    <= 1'b0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            level_q  <= level_d;
            rdata_q  <= rdata_d;
            vld_q    <= vld_d;
        end
    end

    assign rdata = rdata_q;
    assign vld   = vld_q;
    assign level = level_q;

endmodule

// File: rtl/i2s_loop_fifo.sv
// Assembles in-order I2S channel samples into frames and buffers them in a FIFO.
// Optional drop/sync-error counter enabled by defining I2S_LOOP_DROP_CNT_EN.
module i2s_loop_fifo
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned DEPTH      = 4
) (
    input  logic            sck,
    input  logic            rst,
    i2s_loop_fifo_if.slave  bus
);
    localparam int unsigned CH_W = sel_w(CHANNELS);
    localparam int unsigned FW   = frame_w(DATA_WIDTH, CHANNELS);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

    asm_state_e      state_q, state_d;
    logic [CH_W-1:0] exp_ch_q, exp_ch_d;
    logic [FW-1:0]   asm_q, asm_d, ins_c;
    logic            sync_err_q, sync_err_d;
    logic            overflow_q, overflow_d;
    logic            push_c, full_c, drop_c;

    // ins_c is the held frame with the incoming sample dropped into its slot.
    always_comb begin
        ins_c = asm_q;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (bus.in_ch == CH_W'(k)) begin
                ins_c[k*DATA_WIDTH +: DATA_WIDTH] = bus.data;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        exp_ch_d   = exp_ch_q;
        asm_d      = asm_q;
        push_c     = 1'b0;
        sync_err_d = 1'b0;
        if (bus.in_vld) begin
            case (state_q)
                IDLE: begin
                    if (bus.in_ch == '0) begin
                        asm_d = ins_c;
                        if (CHANNELS == 1) begin
                            push_c = 1'b1;
                        end else begin
                            state_d  = COLLECT;
                            exp_ch_d = CH_W'(1);
                        end
                    end else begin
                        sync_err_d = 1'b1;
                    end
                end
                COLLECT: begin
                    if (bus.in_ch == exp_ch_q) begin
                        asm_d = ins_c;
                        if (bus.in_ch == LAST_CH) begin
                            push_c   = 1'b1;
                            state_d  = IDLE;
                            exp_ch_d = '0;
                        end else begin
                            exp_ch_d = exp_ch_q + CH_W'(1);
                        end
                    end else begin
                        // Out of order: a channel-0 sample restarts the frame.
                        sync_err_d = 1'b1;
                        if (bus.in_ch == '0) begin
                            asm_d    = ins_c;
                            exp_ch_d = CH_W'(1);
                        end else begin
                            state_d  = IDLE;
                            exp_ch_d = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign drop_c     = push_c & full_c & ~(bus.out_vld & bus.out_rdy);
    assign overflow_d = drop_c | (overflow_q & ~bus.ovf_clr);

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            exp_ch_q   <= '0;
            asm_q      <= '0;
            sync_err_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_ch_q   <= exp_ch_d;
            asm_q      <= asm_d;
            sync_err_q <= sync_err_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.sync_err = sync_err_q;
    assign bus.overflow = overflow_q;

    i2s_frame_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (sck),
        .rst     (rst),
        .push    (push_c),
        .wdata   (ins_c),
        .pop_rdy (bus.out_rdy),
        .rdata   (bus.frame),
        .vld     (bus.out_vld),
        .level   (bus.level),
        .full_c  (full_c)
    );

`ifdef I2S_LOOP_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d, cnt_base_c;

    // Clear takes effect first so an event in the clearing cycle still counts.
    always_comb begin
        cnt_base_c = bus.ovf_clr ? 16'd0 : drop_cnt_q;
        drop_cnt_d = cnt_base_c;
        if ((drop_c | sync_err_d) && (cnt_base_c != 16'hFFFF)) begin
            drop_cnt_d = cnt_base_c + 16'd1;
        end
    end

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_loop_fifo.sv
// Scoreboard bench for i2s_loop_fifo: directed scenarios plus random traffic
// against a queue-based frame/FIFO model; a second 4x16 instance is spot-checked.
module tb_i2s_loop_fifo;

    localparam int unsigned DW_A = 8,  CH_A = 2, DEPTH_A = 4;
    localparam int unsigned DW_B = 16, CH_B = 4, DEPTH_B = 4;

    typedef struct {
        int cyc;
        int lvl;
        bit ovf;
        bit serr;
        int cnt;
    } stat_t;

    logic sck = 1'b0;
    logic rst = 1'b1;
    int   edge_n = 0;
    int   total = 0;
    int   bad = 0;

    int     part[$];
    longint fq[$];
    longint exp_q[$];
    stat_t  stat_q[$];
    bit     m_ovf = 1'b0;
    int     m_cnt = 0;

    i2s_loop_fifo_if #(.DATA_WIDTH(DW_A), .CHANNELS(CH_A), .DEPTH(DEPTH_A)) bus ();
    i2s_loop_fifo_if #(.DATA_WIDTH(DW_B), .CHANNELS(CH_B), .DEPTH(DEPTH_B)) bus_b ();

    i2s_loop_fifo #(.DATA_WIDTH(DW_A), .CHANNELS(CH_A), .DEPTH(DEPTH_A)) dut_a (
        .sck (sck), .rst (rst), .bus (bus.slave)
    );
    i2s_loop_fifo #(.DATA_WIDTH(DW_B), .CHANNELS(CH_B), .DEPTH(DEPTH_B)) dut_b (
        .sck (sck), .rst (rst), .bus (bus_b.slave)
    );

    always #5 sck = ~sck;
    always @(posedge sck) edge_n <= edge_n + 1;

    function automatic void chk(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference behaviour for one clock edge with the given inputs.
    task automatic model(bit vld, int ch, int d, bit rdy, bit clr, int cyc);
        bit     serr = 1'b0;
        bit     drop = 1'b0;
        bit     done = 1'b0;
        longint f = 0;
        if (fq.size() > 0 && rdy) void'(fq.pop_front());
        if (vld) begin
            if (ch == part.size()) begin
                part.push_back(d);
                if (part.size() == CH_A) begin
                    for (int i = 0; i < CH_A; i++) f |= longint'(part[i]) << (i * DW_A);
                    part.delete();
                    done = 1'b1;
                end
            end else begin
                serr = 1'b1;
                part.delete();
                if (ch == 0) part.push_back(d);
            end
        end
        if (done) begin
            if (fq.size() < DEPTH_A) begin
                fq.push_back(f);
                exp_q.push_back(f);
            end else begin
                drop = 1'b1;
            end
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (clr) m_cnt = 0;
        if ((drop || serr) && m_cnt < 65535) m_cnt++;
        stat_q.push_back('{cyc, fq.size(), m_ovf, serr, m_cnt});
    endtask

    task automatic step(bit vld, int ch, int d, bit rdy, bit clr);
        @(posedge sck);
        #2;
        bus.in_vld  = vld;
        bus.in_ch   = 1'(ch);
        bus.data    = 8'(d);
        bus.out_rdy = rdy;
        bus.ovf_clr = clr;
        model(vld, ch, d, rdy, clr, edge_n + 1);
    endtask

    task automatic do_reset();
        @(posedge sck);
        #2;
        rst = 1'b1;
        bus.in_vld  = 1'b0;
        bus.out_rdy = 1'b0;
        bus.ovf_clr = 1'b0;
        part.delete();
        fq.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_cnt = 0;
        stat_q.push_back('{edge_n + 1, 0, 1'b0, 1'b0, 0});
        @(posedge sck);
        #2;
        rst = 1'b0;
    endtask

    task automatic idle(int n, bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, rdy, 1'b0);
    endtask

    // Monitor: mid-cycle sampling of status and of every accepted frame.
    initial begin
        stat_t s;
        longint f;
        forever begin
            @(negedge sck);
            if (rst) begin
                chk("rst_frame", longint'(bus.frame), 0);
                chk("rst_flags", longint'({bus.out_vld, bus.overflow, bus.sync_err, bus.level}), 0);
            end
            while (stat_q.size() > 0 && stat_q[0].cyc < edge_n) void'(stat_q.pop_front());
            if (stat_q.size() > 0 && stat_q[0].cyc == edge_n) begin
                s = stat_q.pop_front();
                if (!rst) begin
                    chk("level", longint'(bus.level), s.lvl);
                    chk("out_vld", longint'(bus.out_vld), longint'(s.lvl != 0));
                    chk("overflow", longint'(bus.overflow), longint'(s.ovf));
                    chk("sync_err", longint'(bus.sync_err), longint'(s.serr));
`ifdef I2S_LOOP_DROP_CNT_EN
                    chk("drop_cnt", longint'(bus.drop_cnt), s.cnt);
`endif
                end
            end
            if (!rst && bus.out_vld && bus.out_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("frame_unexpected", longint'(bus.frame), -1);
                end else begin
                    f = exp_q.pop_front();
                    chk("frame", longint'(bus.frame), f);
                end
            end
        end
    end

    initial begin
        longint b_vals[4] = '{64'h1000, 64'h2001, 64'h3002, 64'h4003};
        bit     got;
        bus.in_vld = 1'b0; bus.in_ch = '0; bus.data = '0; bus.out_rdy = 1'b0; bus.ovf_clr = 1'b0;
        bus_b.in_vld = 1'b0; bus_b.in_ch = '0; bus_b.data = '0; bus_b.out_rdy = 1'b0; bus_b.ovf_clr = 1'b0;
        repeat (3) @(posedge sck);
        #2 rst = 1'b0;

        // Four-channel 16-bit instance: one in-order frame.
        for (int i = 0; i < 4; i++) begin
            @(posedge sck); #2;
            bus_b.in_vld = 1'b1; bus_b.in_ch = 2'(i); bus_b.data = 16'(b_vals[i]);
        end
        @(posedge sck); #2 bus_b.in_vld = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge sck);
            got = bus_b.out_vld;
        end
        chk("b_out_vld", longint'(got), 1);
        chk("b_frame", longint'(bus_b.frame), 64'h4003_3002_2001_1000);
        chk("b_level", longint'(bus_b.level), 1);
        @(posedge sck); #2 bus_b.out_rdy = 1'b1;
        @(posedge sck); #2 bus_b.out_rdy = 1'b0;
        @(negedge sck);
        chk("b_drained", longint'({bus_b.out_vld, bus_b.level}), 0);

        // Basic frame.
        step(1, 0, 8'h11, 1, 0);
        step(1, 1, 8'h22, 1, 0);
        idle(3, 1);

        // Fill past depth, drain, clear.
        for (int i = 1; i <= 5; i++) begin
            step(1, 0, i, 0, 0);
            step(1, 1, i, 0, 0);
        end
        idle(2, 0);
        idle(6, 1);
        step(0, 0, 0, 1, 1);
        idle(1, 1);

        // Full with simultaneous push and pop.
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 8'h10 + i, 0, 0);
            step(1, 1, 8'h20 + i, 0, 0);
        end
        step(1, 0, 8'h06, 0, 0);
        step(1, 1, 8'h06, 1, 0);
        idle(2, 0);
        idle(6, 1);

        // Resync cases.
        step(1, 0, 8'hAA, 1, 0);
        step(1, 0, 8'hBB, 1, 0);
        step(1, 1, 8'hCC, 1, 0);
        idle(2, 1);
        step(1, 1, 8'h77, 1, 0);
        idle(3, 1);

        // Reset in the middle of a frame.
        step(1, 0, 8'h55, 1, 0);
        do_reset();
        step(1, 1, 8'h66, 1, 0);
        idle(3, 1);

        // Random traffic with varying consumer back-pressure.
        for (int blk = 0; blk < 10; blk++) begin
            int rdy_pct = $urandom_range(5, 95);
            for (int i = 0; i < 200; i++) begin
                bit vld = ($urandom_range(0, 9) < 7);
                int ch  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1)) : part.size();
                step(vld, ch, int'($urandom_range(0, 255)), $urandom_range(0, 99) < rdy_pct,
                     $urandom_range(0, 31) == 0);
            end
        end

        idle(10, 1);
        @(negedge sck);
        chk("leftover_frames", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2s_loop_fifo.md
Name: i2s_loop_fifo

Overview:
Parametrised successor to the two-channel I2S capture/loopback stage. Collects per-channel samples from the I2S receiver into complete multi-channel frames. Buffers the frames in a DEPTH-entry FIFO and presents them with a valid/ready handshake to the transmit/processing side. Adds channel-order checking, frame resync, fill level and sticky overflow, none of which the earlier stage had.

Parameters:
DATA_WIDTH, 8, bits per channel sample
CHANNELS, 2, channels per frame (2..8); channel 0 = left, 1 = right
DEPTH, 4, FIFO depth in frames; power of two, >= 2
ADDR_W, $clog2(DEPTH), FIFO pointer width (derived, not overridden)

Ports:
sck  input  1  clock; all logic on posedge
rst  input  1  asynchronous reset, active-high
data  input  DATA_WIDTH  incoming sample
in_vld  input  1  data valid this cycle
in_ch  input  $clog2(CHANNELS) (min 1)  channel index of data
frame  output  CHANNELS*DATA_WIDTH  head frame; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
out_vld  output  1  frame valid
out_rdy  input  1  consumer accepts frame
level  output  ADDR_W+1  frames stored (0..DEPTH)
overflow  output  1  sticky: a completed frame was dropped
ovf_clr  input  1  clears overflow
sync_err  output  1  one-cycle pulse: out-of-order channel detected

Behaviour:
- Reset, asynchronous on rst high: all outputs 0. Assembler goes to IDLE, expected channel 0. Pointers and level 0. Assembly registers 0. Any partial frame or FIFO contents are discarded, including mid-frame.
- Assembler FSM, states IDLE and COLLECT, with exp_ch counter:
  - IDLE, in_vld with in_ch==0: store sample, exp_ch=1, go to COLLECT. If CHANNELS==1 the frame completes immediately instead.
  - IDLE, in_vld with in_ch!=0: sample ignored, sync_err pulses, stay IDLE.
  - COLLECT, in_vld with in_ch==exp_ch: store sample, exp_ch+1. If in_ch==CHANNELS-1: frame complete, push request this cycle, go to IDLE.
  - COLLECT, in_vld with in_ch!=exp_ch: sync_err pulses, partial frame discarded. If in_ch==0 it starts a new frame (exp_ch=1, stay COLLECT); otherwise go to IDLE.
  - in_vld low: no change; no timeout.
- Push: the frame built from held channels plus the current data is written at the same edge. out_vld rises on the next cycle. Latency from last-channel sample to out_vld is 1 cycle. There is no combinational bypass when the FIFO is empty.
- Pop: occurs when out_vld && out_rdy at the edge. frame/out_vld then show the next entry in the following cycle. frame is registered and read from the head entry. frame holds stable while out_vld && !out_rdy.
- Simultaneous push+pop: always legal, including when full; level is unchanged.
- Push with level==DEPTH and no pop: frame dropped, FIFO contents untouched, overflow set.
- overflow: sticky until ovf_clr. If set and ovf_clr occur in the same cycle, set wins.
- Pointers wrap modulo DEPTH. level = wr_cnt - rd_cnt on ADDR_W+1 bits.
- out_vld = (level != 0).

Optional Feature:
I2S_LOOP_DROP_CNT_EN:
- Defined: adds output drop_cnt[15:0].
  - Increments on every dropped frame and every sync_err.
  - Saturates at 0xFFFF.
  - Cleared by rst and by ovf_clr; on the same-cycle conflict it is cleared, then this cycle's event counts.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package i2s_pkg: assembler state encoding (IDLE=0, COLLECT=1), MAX_CHANNELS=8, frame-slice width helper.
- Sub-module i2s_frame_fifo: synchronous FIFO with width CHANNELS*DATA_WIDTH, depth DEPTH, and push/pop/full/level.
- The assembler FSM stays in i2s_loop_fifo.

Test Plan:
- Basic frame (defaults): send data=0x11 ch0, then 0x22 ch1, on consecutive cycles, out_rdy=1. Expect out_vld on the cycle after ch1, frame=0x2211, level 1→0.
- Fill/overflow, out_rdy=0: send 5 complete frames 0x0101..0x0505. Expect level=4 and overflow=1. Pop all: frames come out 0x0101..0x0404, then out_vld=0. ovf_clr clears overflow.
- Full simultaneous: with level=4 and out_rdy=1, complete frame 0x0606 in the pop cycle. Expect no overflow, level stays 4, and 0x0606 is the last frame out.
- Resync: send ch0=0xAA, ch0=0xBB, ch1=0xCC. Expect sync_err pulse on the second ch0 and exactly one frame 0xCCBB. A lone ch1 in IDLE pulses sync_err and produces no frame.
- CHANNELS=4, DATA_WIDTH=16: send ch0..3 = 0x1000,0x2001,0x3002,0x4003. Expect frame=0x4003_3002_2001_1000.
- Reset mid-frame: send ch0=0x55, assert rst for 1 cycle, then send ch1=0x66. Expect all outputs 0, sync_err pulse, no frame. With I2S_LOOP_DROP_CNT_EN, drop_cnt=1.
